wall_query_arbiter: RTL

- Shares the single combinational wall-lookup tile map (x 10-bit, y 9-bit, isWall out) among N movers: Pac-Man plus the ghosts.
- Each mover posts a pixel-coordinate probe with a req/ack handshake.
- The arbiter grants one probe per cycle, round-robin, and drives the map's x/y inputs from a register.
- It captures isWall one cycle later and returns a one-cycle ack with the wall bit to the winning mover.

---
 rtl/wall_query_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wall_query_arbiter.sv
// Round-robin arbiter sharing one combinational wall-lookup map among N movers.
// Optional build macro WALL_QUERY_PAC_PRIORITY_EN gives requester 0 absolute priority.

module wall_query_lane #(
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480
) (
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       ack_i,
    input  logic [9:0] x_i,
    input  logic [8:0] y_i,
    output logic       elig_o,
    output logic       oob_o
);
    // Widen before comparing so limits at the top of the coordinate range still work.
    localparam logic [10:0] XLIM = 11'(X_MAX);
    localparam logic [9:0]  YLIM = 10'(Y_MAX);

    assign elig_o = req_i & ~busy_i & ~ack_i;
    assign oob_o  = ({1'b0, x_i} >= XLIM) | ({1'b0, y_i} >= YLIM);
endmodule

module wall_query_arbiter #(
    parameter int N_REQ = 5,
    parameter int ID_W  = 3,
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*10-1:0] req_x,
    input  logic [N_REQ*9-1:0] req_y,
    output logic [N_REQ-1:0]   ack,
    output logic               is_wall,
    output logic [9:0]         map_x,
    output logic [8:0]         map_y,
    input  logic               map_is_wall,
    output logic [N_REQ-1:0]   busy
);
    logic [N_REQ-1:0][9:0] xs;
    logic [N_REQ-1:0][8:0] ys;
    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      oob;

    logic [N_REQ-1:0] busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             is_wall_q;
    logic [9:0]       map_x_q;
    logic [8:0]       map_y_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic             s1_v_q;
    logic [ID_W-1:0]  s1_id_q;
    logic             s1_oob_q;

    logic             gnt_v;
    logic [ID_W-1:0]  gnt_id;
    logic             rr_upd;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign xs[g] = req_x[g*10 +: 10];
        assign ys[g] = req_y[g*9 +: 9];
        wall_query_lane #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_lane (
            .req_i  (req[g]),
            .busy_i (busy_q[g]),
            .ack_i  (ack_q[g]),
            .x_i    (xs[g]),
            .y_i    (ys[g]),
            .elig_o (elig[g]),
            .oob_o  (oob[g])
        );
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        rr_upd = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[wrap_add(rr_ptr_q, k)]) begin
                gnt_v  = 1'b1;
                gnt_id = wrap_add(rr_ptr_q, k);
                rr_upd = 1'b1;
            end
        end
`ifdef WALL_QUERY_PAC_PRIORITY_EN
        if (elig[0]) begin
            gnt_v  = 1'b1;
            gnt_id = '0;
            rr_upd = 1'b0;
        end
`endif
    end

    // A granted id is never busy, so set and clear never hit the same bit.
    always_comb begin
        busy_d = busy_q;
        ack_d  = '0;
        if (s1_v_q) begin
            busy_d[s1_id_q] = 1'b0;
            ack_d[s1_id_q]  = 1'b1;
        end
        if (gnt_v) busy_d[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            ack_q     <= '0;
            is_wall_q <= 1'b0;
            map_x_q   <= '0;
            map_y_q   <= '0;
            rr_ptr_q  <= '0;
            s1_v_q    <= 1'b0;
            s1_id_q   <= '0;
            s1_oob_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ack_q  <= ack_d;
            s1_v_q <= gnt_v;
            if (s1_v_q) is_wall_q <= map_is_wall | s1_oob_q;
            if (gnt_v) begin
                map_x_q  <= xs[gnt_id];
                map_y_q  <= ys[gnt_id];
                s1_id_q  <= gnt_id;
                s1_oob_q <= oob[gnt_id];
                if (rr_upd)
                    rr_ptr_q <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    assign ack     = ack_q;
    assign is_wall = is_wall_q;
    assign map_x   = map_x_q;
    assign map_y   = map_y_q;
    assign busy    = busy_q;
endmodule
